// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of the shared AES core.
// It grants one requester at a time, latches its command and forwards its byte stream until ack or timeout.
module aes_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_opcode,
  input  logic [2*NREQ-1:0]    req_dest_id,
  input  logic [NREQ-1:0]      req_encdec,
  input  logic [24*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]    req_data,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [1:0]           aes_opcode,
  output logic [1:0]           aes_dest_id,
  output logic [1:0]           aes_source_id,
  output logic                 aes_encdec,
  output logic [23:0]          aes_addr,
  output logic [7:0]           aes_data_in,
  output logic                 aes_valid_in,
  input  logic                 aes_ready_in,
  input  logic                 aes_ack_valid,
  output logic                 aes_ack_ready
);

  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      state_reg;
  logic [1:0]      g_reg;
  logic [1:0]      last_reg;
  logic [1:0]      opcode_reg;
  logic [1:0]      dest_id_reg;
  logic            encdec_reg;
  logic [23:0]     addr_reg;
  logic [CW-1:0]   stall_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] done_reg;
  logic            terr_reg;

  // Per-requester views padded to four entries so a 2-bit index never runs off the end.
  logic            req_arr    [4];
  logic [1:0]      opcode_arr [4];
  logic [1:0]      dest_arr   [4];
  logic            encdec_arr [4];
  logic [23:0]     addr_arr   [4];
  logic [7:0]      data_arr   [4];
  logic            valid_arr  [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
      if (gi < NREQ) begin : g_real
        assign req_arr[gi]    = req[gi];
        assign opcode_arr[gi] = req_opcode[2*gi +: 2];
        assign dest_arr[gi]   = req_dest_id[2*gi +: 2];
        assign encdec_arr[gi] = req_encdec[gi];
        assign addr_arr[gi]   = req_addr[24*gi +: 24];
        assign data_arr[gi]   = req_data[8*gi +: 8];
        assign valid_arr[gi]  = req_valid[gi];
      end else begin : g_absent
        assign req_arr[gi]    = 1'b0;
        assign opcode_arr[gi] = 2'd0;
        assign dest_arr[gi]   = 2'd0;
        assign encdec_arr[gi] = 1'b0;
        assign addr_arr[gi]   = 24'd0;
        assign data_arr[gi]   = 8'd0;
        assign valid_arr[gi]  = 1'b0;
      end
    end
  endgenerate

  logic       active;
  logic       handshake;
  logic       sel_found;
  logic [1:0] sel_idx;
  logic [1:0] cand_idx;
  logic [NREQ-1:0] sel_onehot;
  logic [NREQ-1:0] g_onehot;

  assign active    = (state_reg == S_ACTIVE);
  assign handshake = aes_valid_in & aes_ready_in;

  // Scan downward over the offsets so the last hit is the one closest to last+1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    cand_idx  = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_idx = 2'((int'(last_reg) + k) % NREQ);
      if (req_arr[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot_bits
      assign sel_onehot[gi] = (sel_idx == 2'(gi));
      assign g_onehot[gi]   = (g_reg == 2'(gi));
      assign req_ready[gi]  = active & g_onehot[gi] & aes_ready_in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      g_reg       <= 2'd0;
      last_reg    <= 2'(NREQ-1);
      opcode_reg  <= 2'd0;
      dest_id_reg <= 2'd0;
      encdec_reg  <= 1'b0;
      addr_reg    <= 24'd0;
      stall_reg   <= '0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      terr_reg    <= 1'b0;
    end else begin
      done_reg <= '0;
      terr_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (sel_found) begin
            g_reg       <= sel_idx;
            opcode_reg  <= opcode_arr[sel_idx];
            dest_id_reg <= dest_arr[sel_idx];
            encdec_reg  <= encdec_arr[sel_idx];
            addr_reg    <= addr_arr[sel_idx];
            gnt_reg     <= sel_onehot;
            state_reg   <= S_LOAD;
          end
        end
        S_LOAD: begin
          stall_reg <= '0;
          state_reg <= S_ACTIVE;
        end
        S_ACTIVE: begin
          // Ack beats timeout; a byte moving in the last stall cycle counts as progress.
          if (aes_ack_valid) begin
            gnt_reg   <= '0;
            done_reg  <= g_onehot;
            state_reg <= S_DONE;
          end else if (handshake) begin
            stall_reg <= '0;
          end else if (stall_reg == CW'(TIMEOUT-1)) begin
            gnt_reg   <= '0;
            done_reg  <= g_onehot;
            terr_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            stall_reg <= stall_reg + 1'b1;
          end
        end
        S_DONE: begin
          last_reg  <= g_reg;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign gnt           = gnt_reg;
  assign done          = done_reg;
  assign timeout_err   = terr_reg;
  assign busy          = (state_reg != S_IDLE);
  assign aes_opcode    = opcode_reg;
  assign aes_dest_id   = dest_id_reg;
  assign aes_source_id = g_reg;
  assign aes_encdec    = encdec_reg;
  assign aes_addr      = addr_reg;
  assign aes_data_in   = active ? data_arr[g_reg] : 8'd0;
  assign aes_valid_in  = active & valid_arr[g_reg];
  assign aes_ack_ready = active;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: queued expected bytes and completions are compared as the core side sees them.
module tb_aes_req_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [7:0]   req_opcode;
  logic [7:0]   req_dest_id;
  logic [3:0]   req_encdec;
  logic [95:0]  req_addr;
  logic [31:0]  req_data;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic         timeout_err;
  logic         busy;
  logic [1:0]   aes_opcode;
  logic [1:0]   aes_dest_id;
  logic [1:0]   aes_source_id;
  logic         aes_encdec;
  logic [23:0]  aes_addr;
  logic [7:0]   aes_data_in;
  logic         aes_valid_in;
  logic         aes_ready_in;
  logic         aes_ack_valid;
  logic         aes_ack_ready;

  aes_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode), .req_dest_id(req_dest_id),
    .req_encdec(req_encdec), .req_addr(req_addr), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .gnt(gnt), .done(done), .timeout_err(timeout_err), .busy(busy),
    .aes_opcode(aes_opcode), .aes_dest_id(aes_dest_id), .aes_source_id(aes_source_id),
    .aes_encdec(aes_encdec), .aes_addr(aes_addr), .aes_data_in(aes_data_in),
    .aes_valid_in(aes_valid_in), .aes_ready_in(aes_ready_in), .aes_ack_valid(aes_ack_valid),
    .aes_ack_ready(aes_ack_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] byte_q[$];
  logic [4:0] done_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (gnt == 4'd0 && n < 20) begin
      tick();
      n++;
    end
    check_val("gnt_wait", 32'(gnt != 4'd0), 32'd1);
  endtask

  // Core-side monitor: bytes and completions are popped from the scoreboard as they happen.
  always @(negedge clk) begin
    if (aes_valid_in && aes_ready_in) begin
      if (byte_q.size() == 0) check_val("byte_unexp", 32'(aes_data_in), 32'hFFFF);
      else check_val("byte", 32'(aes_data_in), 32'(byte_q.pop_front()));
    end
    if (done != 4'd0) begin
      $display("txn done=%b timeout_err=%b", done, timeout_err);
      if (done_q.size() == 0) check_val("done_unexp", 32'(done), 32'd0);
      else check_val("done", 32'({timeout_err, done}), 32'(done_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit early;
    rst = 1'b1; req = '0; req_opcode = '0; req_dest_id = '0; req_encdec = '0;
    req_addr = '0; req_data = '0; req_valid = '0; aes_ready_in = 1'b0; aes_ack_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_terr", 32'(timeout_err), 32'd0);
    check_val("rst_addr", 32'(aes_addr), 32'd0);
    check_val("rst_ackrdy", 32'(aes_ack_ready), 32'd0);

    // Single requester with three bytes.
    req = 4'b0001; req_opcode[1:0] = 2'b01; req_dest_id[1:0] = 2'b10; req_encdec[0] = 1'b1;
    req_addr[23:0] = 24'h123456;
    done_q.push_back({1'b0, 4'b0001});
    byte_q.push_back(8'hA1); byte_q.push_back(8'hB2); byte_q.push_back(8'hC3);
    tick();
    check_val("t1_gnt", 32'(gnt), 32'h1);
    check_val("t1_src", 32'(aes_source_id), 32'd0);
    check_val("t1_addr", 32'(aes_addr), 32'h123456);
    check_val("t1_opc", 32'(aes_opcode), 32'd1);
    check_val("t1_dest", 32'(aes_dest_id), 32'd2);
    check_val("t1_load_valid", 32'(aes_valid_in), 32'd0);
    check_val("t1_load_ackrdy", 32'(aes_ack_ready), 32'd0);
    req_opcode[1:0] = 2'b11;
    req_addr[23:0] = 24'hFFFFFF;
    tick();
    check_val("t1_ackrdy", 32'(aes_ack_ready), 32'd1);
    aes_ready_in = 1'b1; req_valid[0] = 1'b1; req_data[7:0] = 8'hA1;
    tick(); req_data[7:0] = 8'hB2;
    tick(); req_data[7:0] = 8'hC3;
    tick(); req_valid[0] = 1'b0; aes_ack_valid = 1'b1; req = 4'b0000;
    check_val("t1_opc_stable", 32'(aes_opcode), 32'd1);
    check_val("t1_addr_stable", 32'(aes_addr), 32'h123456);
    tick(); aes_ack_valid = 1'b0;
    check_val("t1_done", 32'(done), 32'h1);
    check_val("t1_done_gnt", 32'(gnt), 32'd0);
    tick();
    check_val("t1_busy_low", 32'(busy), 32'd0);

    // Round robin over all four requesters, each acked immediately.
    rst = 1'b1; tick(); rst = 1'b0;
    aes_ready_in = 1'b0;
    for (int t = 0; t < 8; t++) done_q.push_back({1'b0, 4'(1 << (t % 4))});
    req = 4'b1111; aes_ack_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      wait_gnt();
      check_val("rr_gnt", 32'(gnt), 32'(1 << (t % 4)));
      if (t == 7) req = 4'b0000;
      tick(); tick(); tick();
    end
    tick(); tick();
    aes_ack_valid = 1'b0;
    check_val("rr_drain", 32'(done_q.size()), 32'd0);

    // Backpressure on requester 2; requester 0 also offers bytes but is not granted.
    req = 4'b0100;
    done_q.push_back({1'b0, 4'b0100});
    byte_q.push_back(8'h11); byte_q.push_back(8'h22);
    wait_gnt();
    check_val("bp_gnt", 32'(gnt), 32'h4);
    check_val("bp_src", 32'(aes_source_id), 32'd2);
    tick();
    aes_ready_in = 1'b0; req_valid = 4'b0101; req_data[23:16] = 8'h11; req_data[7:0] = 8'h55;
    repeat (5) begin
      #1;
      check_val("bp_valid", 32'(aes_valid_in), 32'd1);
      check_val("bp_data", 32'(aes_data_in), 32'h11);
      check_val("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    aes_ready_in = 1'b1;
    #1;
    check_val("bp_ready_on", 32'(req_ready), 32'h4);
    tick(); req_data[23:16] = 8'h22;
    tick(); req_valid = 4'b0000; aes_ack_valid = 1'b1; req = 4'b0000;
    tick(); aes_ack_valid = 1'b0; aes_ready_in = 1'b0;
    tick(); tick();
    check_val("bp_bytes_left", 32'(byte_q.size()), 32'd0);

    // Timeout on requester 0, then ack in the final stall cycle on requester 1.
    req = 4'b0011;
    done_q.push_back({1'b1, 4'b0001});
    done_q.push_back({1'b0, 4'b0010});
    wait_gnt();
    check_val("to_gnt", 32'(gnt), 32'h1);
    tick();
    early = 1'b0;
    repeat (TIMEOUT - 1) begin
      tick();
      if (done != 4'd0) early = 1'b1;
    end
    check_val("to_early", 32'(early), 32'd0);
    tick();
    check_val("to_done", 32'(done), 32'h1);
    check_val("to_terr", 32'(timeout_err), 32'd1);
    tick(); tick();
    check_val("to_next_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    repeat (TIMEOUT - 1) tick();
    aes_ack_valid = 1'b1;
    tick();
    aes_ack_valid = 1'b0;
    check_val("avt_done", 32'(done), 32'h2);
    check_val("avt_terr", 32'(timeout_err), 32'd0);
    tick();

    // Reset in the middle of an ACTIVE transaction.
    req = 4'b0100;
    wait_gnt();
    tick(); tick();
    req = 4'b1010; rst = 1'b1;
    tick();
    check_val("mr_gnt", 32'(gnt), 32'd0);
    check_val("mr_busy", 32'(busy), 32'd0);
    check_val("mr_done", 32'(done), 32'd0);
    rst = 1'b0;
    done_q.push_back({1'b0, 4'b0010});
    tick();
    check_val("mr_next_gnt", 32'(gnt), 32'h2);
    req = 4'b0000; aes_ack_valid = 1'b1;
    tick(); tick();
    aes_ack_valid = 1'b0;
    tick(); tick();

    check_val("end_done_q", 32'(done_q.size()), 32'd0);
    check_val("end_byte_q", 32'(byte_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
